// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator advancing on a pixel clock-enable,
// with programmable sync polarity and a configurable output register pipeline.
module vga_timing_gen #(
    parameter int H_PW     = 96,
    parameter int H_BP     = 48,
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int V_PW     = 2,
    parameter int V_BP     = 29,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 0,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          resync,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);
    localparam int H_TOTAL = H_PW + H_BP + H_DISP + H_FP;
    localparam int V_TOTAL = V_PW + V_BP + V_DISP + V_FP;
    localparam int W       = 2 * CW + 5;
    localparam int PW      = (PIPE_DLY + 1) * W;
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_PW_C  = CW'(H_PW);
    localparam logic [CW-1:0] V_PW_C  = CW'(V_PW);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_PW + H_BP);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_PW + V_BP);
    localparam logic [CW-1:0] H_END_C = CW'(H_PW + H_BP + H_DISP);
    localparam logic [CW-1:0] V_END_C = CW'(V_PW + V_BP + V_DISP);
    localparam logic [W-1:0]  RST_V   = {~HS_POL, ~VS_POL, {(W - 2){1'b0}}};

    if (PIPE_DLY < 0 || PIPE_DLY > 3 || H_DISP <= 0 || V_DISP <= 0) begin : g_bad_cfg
        $error("vga_timing_gen: PIPE_DLY must be 0..3 and display sizes non-zero");
    end
    if (CW < 1 || CW > 30 || H_TOTAL - 1 >= (1 << CW) || V_TOTAL - 1 >= (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] h_q, h_d, v_q, v_d, x_c, y_c;
    logic          h_wrap, v_wrap, hs_act, vs_act, h_de, v_de, de_c;
    logic [W-1:0]  dec;
    logic [PW-1:0] pipe_q, pipe_d;

    always_comb begin
        h_wrap = h_q == H_LAST;
        v_wrap = v_q == V_LAST;
        h_d    = (resync || h_wrap) ? '0 : h_q + CW'(1);
        v_d    = (resync || (h_wrap && v_wrap)) ? '0 : h_wrap ? v_q + CW'(1) : v_q;
        hs_act = h_q < H_PW_C;
        vs_act = v_q < V_PW_C;
        h_de   = h_q >= H_ACT_C && h_q < H_END_C;
        v_de   = v_q >= V_ACT_C && v_q < V_END_C;
        de_c   = h_de && v_de;
        x_c    = de_c ? h_q - H_ACT_C : '0;
        y_c    = de_c ? v_q - V_ACT_C : '0;
        dec    = {hs_act ~^ HS_POL, vs_act ~^ VS_POL, de_c, x_c, y_c, h_q == '0, h_q == '0 && v_q == '0};
        // stage 0 sits in the low word; each enable shifts older stages up
        pipe_d = (pipe_q << W) | PW'(dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            pipe_q <= {(PIPE_DLY + 1){RST_V}};
        end else if (pix_ce) begin
            h_q    <= h_d;
            v_q    <= v_d;
            pipe_q <= pipe_d;
        end
    end

    assign {hsync, vsync, de, x, y, line_start, frame_start} = pipe_q[PW-1 -: W];
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator; successor to the fixed 640x480 sync block. Advances horizontal/vertical counters on a pixel clock-enable, not an internally derived clock. Produces programmable-polarity sync, data-enable, active-area pixel coordinates and line/frame start strobes. Outputs are delayed by a configurable pipeline depth so they stay aligned with downstream pixel-generation logic (paddles, ball, score).

## Interface
- H_PW, 96, horizontal sync pulse width (pixels)
- H_BP, 48, horizontal back porch
- H_DISP, 640, horizontal active pixels
- H_FP, 16, horizontal front porch
- V_PW, 2, vertical sync width (lines)
- V_BP, 29, vertical back porch
- V_DISP, 480, vertical active lines
- V_FP, 10, vertical front porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIPE_DLY, 0, extra output register stages (0..3)
- CW, 11, counter and coordinate width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel clock-enable; all state advances only on clk edges with pix_ce=1
- resync  in  1  synchronous frame restart request
- hsync  out  1  horizontal sync at HS_POL level during pulse
- vsync  out  1  vertical sync at VS_POL level during pulse
- de  out  1  active-video flag
- x  out  CW  active-area column, 0..H_DISP-1; 0 when de=0
- y  out  CW  active-area row, 0..V_DISP-1; 0 when de=0
- line_start  out  1  one-pix_ce strobe at h_cnt=0
- frame_start  out  1  one-pix_ce strobe at h_cnt=0, v_cnt=0

## Operation
- H_TOTAL = H_PW+H_BP+H_DISP+H_FP; V_TOTAL = V_PW+V_BP+V_DISP+V_FP. Period is exactly H_TOTAL pixels by V_TOTAL lines, with no extra count.
- Line order: sync, back porch, display, front porch. The vertical axis follows the same order.
- h_cnt runs 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps from V_TOTAL-1 to 0 on the same edge as h_cnt wraps.
- Combinational decode from (h_cnt, v_cnt):
  - hs_act = h_cnt < H_PW
  - vs_act = v_cnt < V_PW
  - h_de = H_PW+H_BP <= h_cnt < H_PW+H_BP+H_DISP; v_de is analogous
  - de = h_de & v_de
  - x = h_cnt-(H_PW+H_BP) and y = v_cnt-(V_PW+V_BP) when de, else 0
- Stage-0 output registers capture the decode on each pix_ce edge. PIPE_DLY further stages follow, also qualified by pix_ce.
- hsync = hs_act XNOR HS_POL; vsync = vs_act XNOR VS_POL.
- resync=1 on a pix_ce edge loads h_cnt=v_cnt=0 instead of incrementing. resync with pix_ce=0 is ignored (not latched).
- resync takes priority over wrap. rst takes priority over everything.
- Elaboration rules:
  - CW must hold H_TOTAL-1 and V_TOTAL-1.
  - PIPE_DLY > 3 or any zero-width DISP is a parameter error; flag it with a generate-time $error.

## Timing
- rst asserted (async): counters = 0. All output stages go to inactive values: hsync = ~HS_POL, vsync = ~VS_POL, de=0, x=y=0, line_start=frame_start=0.
- Latency: outputs reflect the counter value held before edge k of pix_ce, and become visible after edge k+PIPE_DLY.
  - First pix_ce edge after rst release (PIPE_DLY=0): frame_start=1, line_start=1, hsync and vsync active.
- pix_ce=0: counters and every pipeline stage hold. Strobes stay asserted for the whole hold. The "one-pix_ce" width is counted in enabled cycles, not clk cycles.
- de rises at h_cnt=H_PW+H_BP with x=0 and falls after x=H_DISP-1, on rows where v_de holds.
- Reset asserted mid-frame clears state immediately. The restart is identical to power-up.
- pix_ce tied to 1 is legal: one pixel per clk.

## Test plan
- Defaults, pix_ce=1, release rst:
  - frame_start pulses every 800*521=416800 clks
  - line_start every 800 clks
  - hsync low for 96 clks per line; vsync low for 1600 clks per frame
- Defaults, count de per frame: exactly 640*480=307200 cycles.
  - First de has x=0, y=0, at h_cnt=144, v_cnt=31.
  - Last de has x=639, y=479.
- pix_ce asserted every 4th clk: all periods scale by 4. Strobes are 4 clks wide. Outputs are stable between enables.
- PIPE_DLY=2, HS_POL=1, VS_POL=1:
  - Sync, de and x/y sequences equal the PIPE_DLY=0 run shifted by 2 enabled cycles.
  - hsync is active-high.
- resync at h_cnt=300, v_cnt=200 with pix_ce=1: next output is frame_start=1 with sync active. The following frame is full length (416800 enables).
- rst pulsed for 1 clk mid-line (async, between edges): outputs go inactive immediately. Post-release behaviour matches the first test cycle-for-cycle.
